// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Brief    : Shared constants for the 7-segment scan reader: segment
//            patterns (bit6=a .. bit0=g, active-high), digit codes and the
//            acceptance FSM state type.
// Revision : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // Segment patterns as seen after any polarity correction
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Non-decimal digit codes
    localparam logic [3:0] CODE_A     = 4'd10;
    localparam logic [3:0] CODE_INV   = 4'd14;
    localparam logic [3:0] CODE_BLANK = 4'd15;

    // Acceptance FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        ACCEPT = 2'd2,
        HELD   = 2'd3
    } seg7_state_e;

    // True when a code is a plain decimal digit
    function automatic logic is_decimal(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_pattern_decode.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pattern_decode
// Brief    : Combinational 7-segment pattern to 4-bit code lookup. Digits
//            0-9 map to their value, 'A' to 10, blank to 15 and every other
//            pattern to 14 with the invalid flag raised.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_pattern_decode (
    input  logic [6:0] pattern,
    output logic [3:0] code,
    output logic       invalid
);
    import seg7_pkg::*;

    // Pattern lookup; anything not in the table is reported as invalid
    always_comb begin
        code    = CODE_INV;
        invalid = 1'b0;
        case (pattern)
            SEG_0:     code = 4'd0;
            SEG_1:     code = 4'd1;
            SEG_2:     code = 4'd2;
            SEG_3:     code = 4'd3;
            SEG_4:     code = 4'd4;
            SEG_5:     code = 4'd5;
            SEG_6:     code = 4'd6;
            SEG_7:     code = 4'd7;
            SEG_8:     code = 4'd8;
            SEG_9:     code = 4'd9;
            SEG_A:     code = CODE_A;
            SEG_BLANK: code = CODE_BLANK;
            default:   code = CODE_INV;
        endcase
        invalid = (code == CODE_INV);
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_reader.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_reader
// Brief    : Monitors a multiplexed 7-segment bus (seg + de digit select),
//            filters it for stability, decodes each accepted pattern into a
//            per-digit register and reports digits[1:0] as a binary value.
// Config   : SEG7_ACT_LOW_EN - when defined, seg is inverted at the sample
//            register for common-anode boards; undefined uses seg as-is.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_reader #(
    parameter int NUM_DIGITS    = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg,
    input  logic [2:0]              de,
    input  logic                    clr,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   dvalid,
    output logic                    upd,
    output logic [2:0]              upd_idx,
    output logic [6:0]              value,
    output logic                    value_ok,
    output logic                    err
);
    import seg7_pkg::*;

    localparam logic [7:0] c_stable = 8'(STABLE_CYCLES);

    logic [6:0]  w_seg_in;
    logic [9:0]  r_smp;
    logic [9:0]  r_prev;
    logic        w_same;
    logic [3:0]  w_code;
    logic        w_invalid;
    logic        w_in_range;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_inc;
    seg7_state_e r_state;
    seg7_state_e w_restart_state;
    logic [3:0]  r_dig [NUM_DIGITS];
    logic        w_ok;
    logic [6:0]  w_val;

`ifdef SEG7_ACT_LOW_EN
    assign w_seg_in = ~seg;
`else
    assign w_seg_in = seg;
`endif

    // Sample register plus a one-cycle history used for change detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_smp  <= '0;
            r_prev <= '0;
        end else begin
            r_smp  <= {de, w_seg_in};
            r_prev <= r_smp;
        end
    end

    assign w_same = (r_smp == r_prev);

    // r_prev holds the sample that has been stable for the full count when
    // the FSM sits in ACCEPT, so that is what gets decoded and written.
    seg7_pattern_decode u_decode (
        .pattern (r_prev[6:0]),
        .code    (w_code),
        .invalid (w_invalid)
    );

    assign w_in_range      = (int'(r_prev[9:7]) < NUM_DIGITS);
    assign w_cnt_inc       = (r_cnt >= c_stable) ? r_cnt : r_cnt + 8'd1;
    assign w_restart_state = (c_stable <= 8'd1) ? ACCEPT : COUNT;

    // Acceptance FSM with stability counter, digit register file and flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
            upd     <= 1'b0;
            upd_idx <= 3'd0;
            err     <= 1'b0;
            dvalid  <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_dig[i] <= CODE_BLANK;
            end
        end else if (clr) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
            upd     <= 1'b0;
            err     <= 1'b0;
            dvalid  <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_dig[i] <= CODE_BLANK;
            end
        end else begin
            upd <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt   <= 8'd1;
                    r_state <= COUNT;
                end
                COUNT: begin
                    if (!w_same) begin
                        r_cnt   <= 8'd1;
                        r_state <= w_restart_state;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc >= c_stable) begin
                            r_state <= ACCEPT;
                        end
                    end
                end
                ACCEPT: begin
                    if (w_in_range) begin
                        for (int i = 0; i < NUM_DIGITS; i++) begin
                            if (r_prev[9:7] == 3'(i)) begin
                                r_dig[i]  <= w_code;
                                dvalid[i] <= 1'b1;
                            end
                        end
                        upd     <= 1'b1;
                        upd_idx <= r_prev[9:7];
                        if (w_invalid) begin
                            err <= 1'b1;
                        end
                    end
                    // A change landing in this very cycle must not be lost,
                    // so restart counting instead of parking in HELD.
                    if (w_same) begin
                        r_state <= HELD;
                    end else begin
                        r_cnt   <= 8'd1;
                        r_state <= w_restart_state;
                    end
                end
                HELD: begin
                    if (!w_same) begin
                        r_cnt   <= 8'd1;
                        r_state <= w_restart_state;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_ok  = dvalid[0] & dvalid[1] & is_decimal(r_dig[0]) & is_decimal(r_dig[1]);
    assign w_val = 7'(r_dig[1]) * 7'd10 + 7'(r_dig[0]);

    // Registered tens/ones value, one cycle behind the digit registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value    <= 7'd0;
            value_ok <= 1'b0;
        end else if (clr) begin
            value    <= 7'd0;
            value_ok <= 1'b0;
        end else begin
            value_ok <= w_ok;
            value    <= w_ok ? w_val : 7'd0;
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digits
        assign digits[4*g +: 4] = r_dig[g];
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_reader
// Brief    : Self-checking bench for seg7_scan_reader: a vector table of
//            stable digit patterns plus hand-written sequences for filtering,
//            sticky error, clear-vs-accept and mid-count reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_reader;

    localparam int ND = 8;
    localparam int SC = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [6:0]    seg;
    logic [2:0]    de;
    logic          clr;
    logic [4*ND-1:0] digits;
    logic [ND-1:0] dvalid;
    logic          upd;
    logic [2:0]    upd_idx;
    logic [6:0]    value;
    logic          value_ok;
    logic          err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seg7_scan_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .seg      (seg),
        .de       (de),
        .clr      (clr),
        .digits   (digits),
        .dvalid   (dvalid),
        .upd      (upd),
        .upd_idx  (upd_idx),
        .value    (value),
        .value_ok (value_ok),
        .err      (err)
    );

    typedef struct {
        logic [2:0] de;
        logic [6:0] seg;
        logic [3:0] code;
        logic [6:0] val;
        logic       ok;
    } vec_t;

    vec_t vt [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Drive {de,seg}, then watch n falling edges for upd pulses
    task automatic drive_hold(input logic [2:0] d, input logic [6:0] s, input int n,
                              output int ups, output int first, output logic [2:0] idx);
        de    = d;
        seg   = s;
        ups   = 0;
        first = -1;
        idx   = 3'd0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (upd) begin
                ups++;
                if (first < 0) first = k;
                idx = upd_idx;
            end
        end
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ups;
        int first;
        logic [2:0] idx;
        logic [ND-1:0] exp_dv;

        vt[0]  = '{3'd0, 7'b1111001, 4'd3,  7'd0,  1'b0};
        vt[1]  = '{3'd1, 7'b1111111, 4'd8,  7'd83, 1'b1};
        vt[2]  = '{3'd0, 7'b1011011, 4'd5,  7'd85, 1'b1};
        vt[3]  = '{3'd2, 7'b1111110, 4'd0,  7'd85, 1'b1};
        vt[4]  = '{3'd3, 7'b0110000, 4'd1,  7'd85, 1'b1};
        vt[5]  = '{3'd4, 7'b1101101, 4'd2,  7'd85, 1'b1};
        vt[6]  = '{3'd5, 7'b0110011, 4'd4,  7'd85, 1'b1};
        vt[7]  = '{3'd6, 7'b1011111, 4'd6,  7'd85, 1'b1};
        vt[8]  = '{3'd7, 7'b1110000, 4'd7,  7'd85, 1'b1};
        vt[9]  = '{3'd3, 7'b1111011, 4'd9,  7'd85, 1'b1};
        vt[10] = '{3'd4, 7'b1110111, 4'd10, 7'd85, 1'b1};
        vt[11] = '{3'd5, 7'b0000000, 4'd15, 7'd85, 1'b1};
        vt[12] = '{3'd0, 7'b1111011, 4'd9,  7'd89, 1'b1};
        vt[13] = '{3'd1, 7'b0000000, 4'd15, 7'd0,  1'b0};

        // Reset state
        rst_n = 1'b0;
        clr   = 1'b0;
        de    = 3'd0;
        seg   = 7'd0;
        repeat (2) @(negedge clk);
        chk("rst_digits",   digits,   32'hFFFF_FFFF);
        chk("rst_dvalid",   dvalid,   0);
        chk("rst_upd",      upd,      0);
        chk("rst_err",      err,      0);
        chk("rst_value_ok", value_ok, 0);
        rst_n = 1'b1;

        // Table of stable patterns across all digits
        exp_dv = '0;
        for (int i = 0; i < 14; i++) begin
            drive_hold(vt[i].de, vt[i].seg, 9, ups, first, idx);
            exp_dv[vt[i].de] = 1'b1;
            chk($sformatf("v%0d_upd_count", i), ups, 1);
            chk($sformatf("v%0d_latency", i), first, SC + 2);
            chk($sformatf("v%0d_upd_idx", i), idx, vt[i].de);
            chk($sformatf("v%0d_code", i), digits[4*int'(vt[i].de) +: 4], vt[i].code);
            chk($sformatf("v%0d_dvalid", i), dvalid, exp_dv);
            chk($sformatf("v%0d_value", i), value, vt[i].val);
            chk($sformatf("v%0d_value_ok", i), value_ok, vt[i].ok);
            chk($sformatf("v%0d_err", i), err, 0);
        end
        chk("table_all_digits", digits, 32'h76FA_90F9);

        // Pattern toggling faster than the filter never gets accepted
        pulse_clr();
        chk("clr_dvalid", dvalid, 0);
        chk("clr_digits", digits, 32'hFFFF_FFFF);
        begin
            int tot;
            tot = 0;
            for (int t = 0; t < 12; t++) begin
                drive_hold(3'd0, (t % 2 == 0) ? 7'b0110000 : 7'b1101101, 2, ups, first, idx);
                tot += ups;
            end
            chk("toggle_no_upd", tot, 0);
        end
        chk("toggle_digits", digits, 32'hFFFF_FFFF);
        chk("toggle_dvalid", dvalid, 0);

        // Undecodable pattern sets a sticky error
        drive_hold(3'd2, 7'b1000001, 9, ups, first, idx);
        chk("inv_upd_count", ups, 1);
        chk("inv_code", digits[11:8], 4'd14);
        chk("inv_err", err, 1);
        chk("inv_dvalid", dvalid, 8'h04);
        drive_hold(3'd0, 7'b1111110, 9, ups, first, idx);
        chk("inv_then_valid_code", digits[3:0], 4'd0);
        chk("inv_err_sticky", err, 1);
        pulse_clr();
        chk("inv_clr_err", err, 0);
        chk("inv_clr_dvalid", dvalid, 0);
        drive_hold(3'd0, 7'b1111110, 9, ups, first, idx);

        // Clear asserted in the ACCEPT cycle suppresses the write
        drive_hold(3'd7, 7'b1110111, 5, ups, first, idx);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clracc_early_upd", ups, 0);
        chk("clracc_upd", upd, 0);
        chk("clracc_dvalid", dvalid, 0);
        chk("clracc_digit7", digits[31:28], 4'hF);
        drive_hold(3'd7, 7'b1110111, 9, ups, first, idx);
        chk("reacc_dvalid", dvalid, 8'h80);
        chk("reacc_digit7", digits[31:28], 4'd10);

        // Reset mid-count, then the same stable input is accepted normally
        de  = 3'd1;
        seg = 7'b1101101;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_digits",   digits,   32'hFFFF_FFFF);
        chk("midrst_dvalid",   dvalid,   0);
        chk("midrst_upd",      upd,      0);
        chk("midrst_upd_idx",  upd_idx,  0);
        chk("midrst_err",      err,      0);
        chk("midrst_value",    value,    0);
        chk("midrst_value_ok", value_ok, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive_hold(3'd1, 7'b1101101, 12, ups, first, idx);
        chk("postrst_upd_count", ups, 1);
        chk("postrst_latency", first, SC + 2);
        chk("postrst_upd_idx", idx, 3'd1);
        chk("postrst_code", digits[7:4], 4'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
